// File: rtl/cpuregs_pkg.sv
// Shared constants and FSM encoding for the register-file read sequencer.
// Imported by the sequencer top and its capture-select sub-module.
package cpuregs_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RD1   = 3'd2,
        ST_RD2   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/cpuregs_fwd_mux.sv
// Capture-value select for one operand index: x0 reads as zero, a same-cycle
// write-back wins over the regfile (which still shows the old value), else rf_rdata.
module cpuregs_fwd_mux
    import cpuregs_pkg::*;
#(
    parameter int XLEN_P = cpuregs_pkg::XLEN,
    parameter int AW_P   = cpuregs_pkg::AW
) (
    input  logic [AW_P-1:0]   idx_i,
    input  logic              wr_en_i,
    input  logic [AW_P-1:0]   wr_addr_i,
    input  logic [XLEN_P-1:0] wr_data_i,
    input  logic [XLEN_P-1:0] rf_rdata_i,
    output logic [XLEN_P-1:0] val_o
);

    // Priority select: zero register, then forwarding, then the array read
    always_comb begin
        val_o = rf_rdata_i;
        if (idx_i == REG_ZERO) begin
            val_o = {XLEN_P{1'b0}};
        end else if (wr_en_i && (wr_addr_i == idx_i)) begin
            val_o = wr_data_i;
        end else begin
            val_o = rf_rdata_i;
        end
    end

endmodule

// File: rtl/cpuregs_rd_seq.sv
// Operand-read sequencer for a single-read-port 32x32 register file: two reads per
// request, valid/ready response, x0 write blocking, forwarding and post-reset zero sweep.
module cpuregs_rd_seq
    import cpuregs_pkg::*;
#(
    parameter int XLEN           = cpuregs_pkg::XLEN,
    parameter int AW             = cpuregs_pkg::AW,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_rs1,
    input  logic [AW-1:0]   req_rs2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rs1_val,
    output logic [XLEN-1:0] rsp_rs2_val,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [AW-1:0]   rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_di
);

    localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

    state_t          state_q;
    logic [AW-1:0]   clr_cnt_q;
    logic [AW-1:0]   rs1_q;
    logic [AW-1:0]   rs2_q;
    logic [XLEN-1:0] op1_q;
    logic [XLEN-1:0] op2_q;
    logic            rsp_valid_q;

    logic [AW-1:0]   cap_idx_d;
    logic [XLEN-1:0] cap_val_d;
    logic            wr_hit_rs1_d;
    logic            wr_hit_rs2_d;

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rs1_val = op1_q;
    assign rsp_rs2_val = op2_q;

    // One shared capture mux; its index follows whichever operand is being read
    always_comb begin
        cap_idx_d = rs1_q;
        if (state_q == ST_RD2) begin
            cap_idx_d = rs2_q;
        end else begin
            cap_idx_d = rs1_q;
        end
    end

    cpuregs_fwd_mux #(
        .XLEN_P (XLEN),
        .AW_P   (AW)
    ) u_fwd_mux (
        .idx_i      (cap_idx_d),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rf_rdata_i (rf_rdata),
        .val_o      (cap_val_d)
    );

    // Late write-backs that must refresh operands already captured
    always_comb begin
        wr_hit_rs1_d = wr_en && (wr_addr == rs1_q) && (rs1_q != REG_ZERO);
        wr_hit_rs2_d = wr_en && (wr_addr == rs2_q) && (rs2_q != REG_ZERO);
    end

    // Read address: only the two read states drive a real index
    always_comb begin
        rf_raddr = {AW{1'b0}};
        case (state_q)
            ST_RD1:  rf_raddr = rs1_q;
            ST_RD2:  rf_raddr = rs2_q;
            default: rf_raddr = {AW{1'b0}};
        endcase
    end

    // Write port: zero sweep during CLEAR, otherwise pass-through with x0 blocked
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = wr_addr;
        rf_di    = wr_data;
        if (state_q == ST_CLEAR) begin
            rf_we    = 1'b1;
            rf_waddr = clr_cnt_q;
            rf_di    = {XLEN{1'b0}};
        end else begin
            rf_we    = wr_en && (wr_addr != REG_ZERO);
            rf_waddr = wr_addr;
            rf_di    = wr_data;
        end
    end

    // Sequencer FSM with operand holds and response valid
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_cnt_q   <= {AW{1'b0}};
            rs1_q       <= {AW{1'b0}};
            rs2_q       <= {AW{1'b0}};
            op1_q       <= {XLEN{1'b0}};
            op2_q       <= {XLEN{1'b0}};
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + CNT_ONE;
                    if (clr_cnt_q == CNT_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_CLEAR;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        rs1_q   <= req_rs1;
                        rs2_q   <= req_rs2;
                        state_q <= ST_RD1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RD1: begin
                    op1_q   <= cap_val_d;
                    state_q <= ST_RD2;
                end
                ST_RD2: begin
                    op2_q <= cap_val_d;
                    if (wr_hit_rs1_d) begin
                        op1_q <= wr_data;
                    end else begin
                        op1_q <= op1_q;
                    end
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (wr_hit_rs1_d) begin
                        op1_q <= wr_data;
                    end else begin
                        op1_q <= op1_q;
                    end
                    if (wr_hit_rs2_d) begin
                        op2_q <= wr_data;
                    end else begin
                        op2_q <= op2_q;
                    end
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
